// File: rtl/writeback_unit_if.sv
// Writeback request, data-memory response and register-file write bundle.
// The slave modport is the writeback_unit side; master is the core/memory side.
interface writeback_unit_if;
    // Retiring instruction request
    logic        wb_valid;
    logic [4:0]  rd_in;
    logic        RUWr_in;
    logic [1:0]  RUDataWrSrc;
    logic [31:0] AluRes;
    logic [31:0] PcInc;
    logic [2:0]  DMCtrl;
    // Data memory response
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    // Register file write side and core control
    logic [4:0]  rd;
    logic [31:0] DataWr;
    logic        RUWr;
    logic        stall;
    logic        load_err;

    modport slave (
        input  wb_valid, rd_in, RUWr_in, RUDataWrSrc, AluRes, PcInc, DMCtrl,
        input  mem_rvalid, mem_rdata,
        output rd, DataWr, RUWr, stall, load_err
    );

    modport master (
        output wb_valid, rd_in, RUWr_in, RUDataWrSrc, AluRes, PcInc, DMCtrl,
        output mem_rvalid, mem_rdata,
        input  rd, DataWr, RUWr, stall, load_err
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: picks ALU / PC+4 / load data for the register file write,
// waits for load data with a timeout, aligns and extends loaded bytes/halves.
// Optional macro WB_RETIRE_CNT_EN adds retire_cnt (write pulses, wrapping)
// and err_cnt (load_err pulses, saturating) outputs.
module writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    writeback_unit_if.slave   wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic        ruwr_q, ruwr_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    // Load context held across WAIT_MEM
    logic [4:0]  lrd_q, lrd_d;
    logic        lwe_q, lwe_d;
    logic [2:0]  lfn_q, lfn_d;
    logic [1:0]  loff_q, loff_d;

    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Misalignment and load-data alignment/extension
    always_comb begin
        misaligned = 1'b0;
        case (wb.DMCtrl)
            3'b001, 3'b101: misaligned = wb.AluRes[0];
            3'b010:         misaligned = (wb.AluRes[1:0] != 2'b00);
            default:        misaligned = 1'b0;
        endcase

        ld_byte = wb.mem_rdata[{loff_q, 3'b000} +: 8];
        ld_half = loff_q[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
        case (lfn_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = wb.mem_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        data_d  = data_q;
        ruwr_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        lrd_d   = lrd_q;
        lwe_d   = lwe_q;
        lfn_d   = lfn_q;
        loff_d  = loff_q;

        case (state_q)
            StIdle: begin
                if (wb.wb_valid) begin
                    if (wb.RUDataWrSrc != 2'b00) begin
                        rd_d   = wb.rd_in;
                        data_d = (wb.RUDataWrSrc == 2'b10) ? wb.PcInc : wb.AluRes;
                        ruwr_d = wb.RUWr_in && (wb.rd_in != 5'd0);
                    end else if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        lrd_d   = wb.rd_in;
                        lwe_d   = wb.RUWr_in;
                        lfn_d   = wb.DMCtrl;
                        loff_d  = wb.AluRes[1:0];
                        cnt_d   = 16'd0;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // Data arriving on the timeout cycle still completes the load
                if (wb.mem_rvalid) begin
                    rd_d    = lrd_q;
                    data_d  = ld_data;
                    ruwr_d  = lwe_q && (lrd_q != 5'd0);
                    state_d = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
            ruwr_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
            lrd_q   <= 5'd0;
            lwe_q   <= 1'b0;
            lfn_q   <= 3'd0;
            loff_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            ruwr_q  <= ruwr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            lrd_q   <= lrd_d;
            lwe_q   <= lwe_d;
            lfn_q   <= lfn_d;
            loff_q  <= loff_d;
        end
    end

    assign wb.rd       = rd_q;
    assign wb.DataWr   = data_q;
    assign wb.RUWr     = ruwr_q;
    assign wb.load_err = err_q;
    // state_q is a flop, so stall is registered and drops with async reset
    assign wb.stall    = (state_q == StWait);

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;
    logic [15:0] errcnt_q;

    // Count write pulses (wrapping) and error pulses (saturating)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= 32'd0;
            errcnt_q <= 16'd0;
        end else begin
            if (ruwr_d) begin
                retire_q <= retire_q + 32'd1;
            end
            if (err_d && (errcnt_q != 16'hFFFF)) begin
                errcnt_q <= errcnt_q + 16'd1;
            end
        end
    end

    assign retire_cnt = retire_q;
    assign err_cnt    = errcnt_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: table of single-cycle writebacks plus
// hand-written load, timeout and reset sequences.
module tb_writeback_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    writeback_unit_if wbif();

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    logic [15:0] err_cnt;
`endif

    writeback_unit #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (wbif)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  rd_in;
        logic        we;
        logic [2:0]  fn;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wbif.wb_valid    = 1'b0;
        wbif.rd_in       = 5'd0;
        wbif.RUWr_in     = 1'b0;
        wbif.RUDataWrSrc = 2'b01;
        wbif.AluRes      = 32'd0;
        wbif.PcInc       = 32'd0;
        wbif.DMCtrl      = 3'd0;
        wbif.mem_rvalid  = 1'b0;
        wbif.mem_rdata   = 32'd0;
    endtask

    task automatic issue_load(input logic [2:0] fn, input logic [1:0] off,
                              input logic [4:0] rdi);
        wbif.wb_valid    = 1'b1;
        wbif.RUDataWrSrc = 2'b00;
        wbif.DMCtrl      = fn;
        wbif.AluRes      = {28'h0000100, 2'b00, off};
        wbif.rd_in       = rdi;
        wbif.RUWr_in     = 1'b1;
        tick();
        wbif.wb_valid    = 1'b0;
    endtask

    // Load returning data on the delay-th edge after issue
    task automatic do_load(input string name, input logic [2:0] fn, input logic [1:0] off,
                           input logic [4:0] rdi, input int delay, input logic [31:0] rdata,
                           input logic [31:0] exp_data);
        issue_load(fn, off, rdi);
        check({name, " stall first"}, {31'd0, wbif.stall}, 32'd1);
        for (int i = 1; i < delay; i++) begin
            tick();
            check({name, " stall hold"}, {31'd0, wbif.stall}, 32'd1);
        end
        wbif.mem_rvalid = 1'b1;
        wbif.mem_rdata  = rdata;
        tick();
        wbif.mem_rvalid = 1'b0;
        check({name, " data"}, wbif.DataWr, exp_data);
        check({name, " rd"}, {27'd0, wbif.rd}, {27'd0, rdi});
        check({name, " RUWr"}, {31'd0, wbif.RUWr}, {31'd0, rdi != 5'd0});
        check({name, " stall end"}, {31'd0, wbif.stall}, 32'd0);
        check({name, " no err"}, {31'd0, wbif.load_err}, 32'd0);
        tick();
        check({name, " RUWr pulse"}, {31'd0, wbif.RUWr}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{2'b01, 5'd5,  1'b1, 3'd0, 32'h0000_1234, 32'h0,  5'd5, 32'h0000_1234, 1'b1, 1'b0};
        vecs[1] = '{2'b10, 5'd0,  1'b1, 3'd0, 32'h0000_9999, 32'h40, 5'd0, 32'h0000_0040, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 5'd7,  1'b1, 3'd0, 32'hDEAD_BEEF, 32'h1,  5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 5'd9,  1'b0, 3'd0, 32'h0000_0055, 32'h8,  5'd9, 32'h0000_0055, 1'b0, 1'b0};
        // Misaligned loads: error pulse, write side holds previous values
        vecs[4] = '{2'b00, 5'd3,  1'b1, 3'b010, 32'h0000_0101, 32'h0, 5'd9, 32'h0000_0055, 1'b0, 1'b1};
        vecs[5] = '{2'b00, 5'd3,  1'b1, 3'b001, 32'h0000_0003, 32'h0, 5'd9, 32'h0000_0055, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 5'd4,  1'b1, 3'b101, 32'h0000_0001, 32'h0, 5'd9, 32'h0000_0055, 1'b0, 1'b1};

        idle_inputs();
        #12;
        check("reset rd", {27'd0, wbif.rd}, 32'd0);
        check("reset DataWr", wbif.DataWr, 32'd0);
        check("reset RUWr", {31'd0, wbif.RUWr}, 32'd0);
        check("reset stall", {31'd0, wbif.stall}, 32'd0);
        check("reset load_err", {31'd0, wbif.load_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // mem_rvalid while idle must do nothing
        wbif.mem_rvalid = 1'b1;
        wbif.mem_rdata  = 32'hFFFF_FFFF;
        tick();
        wbif.mem_rvalid = 1'b0;
        check("idle rvalid RUWr", {31'd0, wbif.RUWr}, 32'd0);
        check("idle rvalid stall", {31'd0, wbif.stall}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            wbif.wb_valid    = 1'b1;
            wbif.RUDataWrSrc = vecs[i].src;
            wbif.rd_in       = vecs[i].rd_in;
            wbif.RUWr_in     = vecs[i].we;
            wbif.DMCtrl      = vecs[i].fn;
            wbif.AluRes      = vecs[i].alu;
            wbif.PcInc       = vecs[i].pc;
            tick();
            wbif.wb_valid = 1'b0;
            check($sformatf("vec%0d rd", i), {27'd0, wbif.rd}, {27'd0, vecs[i].exp_rd});
            check($sformatf("vec%0d DataWr", i), wbif.DataWr, vecs[i].exp_data);
            check($sformatf("vec%0d RUWr", i), {31'd0, wbif.RUWr}, {31'd0, vecs[i].exp_we});
            check($sformatf("vec%0d load_err", i), {31'd0, wbif.load_err},
                  {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d stall", i), {31'd0, wbif.stall}, 32'd0);
            tick();
            check($sformatf("vec%0d RUWr drop", i), {31'd0, wbif.RUWr}, 32'd0);
            check($sformatf("vec%0d err drop", i), {31'd0, wbif.load_err}, 32'd0);
        end

        do_load("LB",      3'b000, 2'd2, 5'd18, 3, 32'h1280_3456, 32'hFFFF_FF80);
        do_load("LBU",     3'b100, 2'd2, 5'd18, 3, 32'h1280_3456, 32'h0000_0080);
        do_load("LB off1", 3'b000, 2'd1, 5'd11, 2, 32'h1280_3456, 32'h0000_0034);
        do_load("LH off2", 3'b001, 2'd2, 5'd12, 1, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("LH off0", 3'b001, 2'd0, 5'd13, 2, 32'h0000_9ABC, 32'hFFFF_9ABC);
        do_load("LHU",     3'b101, 2'd0, 5'd14, 1, 32'h8001_7FFF, 32'h0000_7FFF);
        do_load("LW x0",   3'b010, 2'd0, 5'd0,  1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        // Data arriving on the timeout edge wins
        do_load("LBU tmo", 3'b100, 2'd3, 5'd15, 4, 32'hA500_0000, 32'h0000_00A5);

        // Timeout: four stall cycles, then error pulse; late data ignored
        issue_load(3'b010, 2'd0, 5'd4);
        check("tmo stall 0", {31'd0, wbif.stall}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("tmo stall %0d", i), {31'd0, wbif.stall}, 32'd1);
        end
        tick();
        check("tmo load_err", {31'd0, wbif.load_err}, 32'd1);
        check("tmo RUWr", {31'd0, wbif.RUWr}, 32'd0);
        check("tmo stall drop", {31'd0, wbif.stall}, 32'd0);
        wbif.mem_rvalid = 1'b1;
        wbif.mem_rdata  = 32'h1111_2222;
        tick();
        wbif.mem_rvalid = 1'b0;
        check("late RUWr", {31'd0, wbif.RUWr}, 32'd0);
        check("late err", {31'd0, wbif.load_err}, 32'd0);
        check("late DataWr", wbif.DataWr, 32'h0000_00A5);
        check("late stall", {31'd0, wbif.stall}, 32'd0);

        // Reset two cycles into a load
        issue_load(3'b010, 2'd0, 5'd6);
        tick();
        check("pre-rst stall", {31'd0, wbif.stall}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst stall async", {31'd0, wbif.stall}, 32'd0);
        check("rst RUWr", {31'd0, wbif.RUWr}, 32'd0);
        check("rst rd", {27'd0, wbif.rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wbif.mem_rvalid = 1'b1;
        wbif.mem_rdata  = 32'h3333_4444;
        tick();
        wbif.mem_rvalid = 1'b0;
        check("post-rst RUWr", {31'd0, wbif.RUWr}, 32'd0);
        wbif.wb_valid    = 1'b1;
        wbif.RUDataWrSrc = 2'b01;
        wbif.rd_in       = 5'd10;
        wbif.RUWr_in     = 1'b1;
        wbif.AluRes      = 32'h0000_0077;
        tick();
        wbif.wb_valid = 1'b0;
        check("post-rst ALU rd", {27'd0, wbif.rd}, 32'd10);
        check("post-rst ALU data", wbif.DataWr, 32'h0000_0077);
        check("post-rst ALU RUWr", {31'd0, wbif.RUWr}, 32'd1);
`ifdef WB_RETIRE_CNT_EN
        check("retire_cnt", retire_cnt, 32'd1);
        check("err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
